// File: rtl/lns_log_multiply_stage_if.sv
// Operand/result bus of the LNS log-domain multiply stage.
// The slave modport is the stage side; the master modport is the producer/consumer side.
interface lns_log_multiply_stage_if #(
  parameter int unsigned X_BITS   = 8,
  parameter int unsigned INT_BITS = 8
);
  logic [INT_BITS-1:0] a_int;
  logic [X_BITS-1:0]   a_frac;
  logic                a_sign;
  logic                a_zero;
  logic [INT_BITS-1:0] b_int;
  logic [X_BITS-1:0]   b_frac;
  logic                b_sign;
  logic                b_zero;
  logic                data_in_valid;
  logic                data_in_enable;
  logic [X_BITS-1:0]   data_out_frac;
  logic [INT_BITS-1:0] data_out_int;
  logic                data_out_sign;
  logic                data_out_zero;
  logic                data_out_sat;
  logic                data_out_valid;
  logic                data_out_enable;

  modport slave (
    input  a_int, a_frac, a_sign, a_zero,
    input  b_int, b_frac, b_sign, b_zero,
    input  data_in_valid, data_out_enable,
    output data_in_enable,
    output data_out_frac, data_out_int, data_out_sign, data_out_zero, data_out_sat,
    output data_out_valid
  );

  modport master (
    output a_int, a_frac, a_sign, a_zero,
    output b_int, b_frac, b_sign, b_zero,
    output data_in_valid, data_out_enable,
    input  data_in_enable,
    input  data_out_frac, data_out_int, data_out_sign, data_out_zero, data_out_sat,
    input  data_out_valid
  );
endinterface

// File: rtl/lns_log_multiply_stage.sv
// LNS multiply stage: saturating log-magnitude add, sign XOR, zero propagation,
// results queued in a small FIFO ahead of the exponentiator.
module lns_log_multiply_stage #(
  parameter int unsigned X_BITS   = 8,
  parameter int unsigned INT_BITS = 8,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  lns_log_multiply_stage_if.slave bus
);
  localparam int unsigned W     = INT_BITS + X_BITS;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INT_BITS-1:0] ipart;
    logic [X_BITS-1:0]   frac;
    logic                sign;
    logic                zero;
    logic                sat;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [W:0]         sum_c;
  logic [W-1:0]       log_c;
  logic               ovf_c;
  entry_t             result_c;
  entry_t             head_c;
  logic               push_c;
  logic               pop_c;

  // Sign-extended add at W+1 bits; disagreement of the top two bits means overflow.
  always_comb begin
    sum_c = {bus.a_int[INT_BITS-1], bus.a_int, bus.a_frac}
          + {bus.b_int[INT_BITS-1], bus.b_int, bus.b_frac};
    ovf_c = sum_c[W] ^ sum_c[W-1];
    if (!ovf_c)        log_c = sum_c[W-1:0];
    else if (sum_c[W]) log_c = {1'b1, {(W-1){1'b0}}};
    else               log_c = {1'b0, {(W-1){1'b1}}};

    result_c = '0;
    if (bus.a_zero || bus.b_zero) begin
      result_c.zero = 1'b1;
    end else begin
      result_c.ipart = log_c[W-1:X_BITS];
      result_c.frac  = log_c[X_BITS-1:0];
      result_c.sign  = bus.a_sign ^ bus.b_sign;
      result_c.sat   = ovf_c;
    end
  end

  assign push_c = bus.data_in_valid && (count_q != CNT_W'(DEPTH));
  assign pop_c  = (count_q != '0) && bus.data_out_enable;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = result_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry is blanked when empty so no stale result is ever shown.
  assign head_c = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  assign bus.data_in_enable = (count_q != CNT_W'(DEPTH));
  assign bus.data_out_valid = (count_q != '0);
  assign bus.data_out_int   = head_c.ipart;
  assign bus.data_out_frac  = head_c.frac;
  assign bus.data_out_sign  = head_c.sign;
  assign bus.data_out_zero  = head_c.zero;
  assign bus.data_out_sat   = head_c.sat;
endmodule

// File: tb/tb_lns_log_multiply_stage.sv
// Scoreboard bench for lns_log_multiply_stage: directed and random operand pairs
// checked against an integer-arithmetic model of the log-domain product.
module tb_lns_log_multiply_stage;
  localparam int unsigned XB = 8;
  localparam int unsigned IB = 8;
  localparam int unsigned DP = 2;

  logic clk;
  logic rstn;
  int   chk_cnt;
  int   pass_cnt;
  bit   rand_ready;

  typedef struct packed {
    logic [IB-1:0] ipart;
    logic [XB-1:0] frac;
    logic          sign;
    logic          zero;
    logic          sat;
  } exp_t;

  exp_t exp_q[$];

  lns_log_multiply_stage_if #(.X_BITS(XB), .INT_BITS(IB)) bus ();

  lns_log_multiply_stage #(.X_BITS(XB), .INT_BITS(IB), .DEPTH(DP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference: real-valued log sum in units of 2^-XB, clamped, then floor-split.
  function automatic exp_t model(input logic [IB-1:0] ai, input logic [XB-1:0] af, input logic as_,
                                 input logic az, input logic [IB-1:0] bi, input logic [XB-1:0] bf,
                                 input logic bs, input logic bz);
    exp_t e;
    int   scale, la, lb, s, hi, lo, ip, fr;
    e = '0;
    if (az || bz) begin
      e.zero = 1'b1;
      return e;
    end
    scale = 1 << XB;
    hi = (1 << (IB + XB - 1)) - 1;
    lo = -(1 << (IB + XB - 1));
    la = int'($signed(ai)) * scale + int'(af);
    lb = int'($signed(bi)) * scale + int'(bf);
    s  = la + lb;
    if (s > hi) begin s = hi; e.sat = 1'b1; end
    if (s < lo) begin s = lo; e.sat = 1'b1; end
    ip = (s >= 0) ? s / scale : -((-s + scale - 1) / scale);
    fr = s - ip * scale;
    e.ipart = IB'(ip);
    e.frac  = XB'(fr);
    e.sign  = as_ ^ bs;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.ipart = bus.data_out_int;
    o.frac  = bus.data_out_frac;
    o.sign  = bus.data_out_sign;
    o.zero  = bus.data_out_zero;
    o.sat   = bus.data_out_sat;
    return o;
  endfunction

  // Monitor: records accepted pushes and checks pops / stalled heads against the queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(bus.data_out_valid), 32'd0);
        end else if (bus.data_out_enable) begin
          check("pop_data", 32'(observed()), 32'(exp_q.pop_front()));
        end else begin
          check("stall_head", 32'(observed()), 32'(exp_q[0]));
        end
      end
      if (bus.data_in_valid && bus.data_in_enable)
        exp_q.push_back(model(bus.a_int, bus.a_frac, bus.a_sign, bus.a_zero,
                              bus.b_int, bus.b_frac, bus.b_sign, bus.b_zero));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.data_out_enable = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [IB-1:0] ai, input logic [XB-1:0] af, input logic as_, input logic az,
                      input logic [IB-1:0] bi, input logic [XB-1:0] bf, input logic bs, input logic bz);
    bit acc;
    int n;
    bus.a_int = ai; bus.a_frac = af; bus.a_sign = as_; bus.a_zero = az;
    bus.b_int = bi; bus.b_frac = bf; bus.b_sign = bs; bus.b_zero = bz;
    bus.data_in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      acc = bus.data_in_enable;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    bus.data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.data_out_enable = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.data_out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    rand_ready = 1'b0;
    rstn = 1'b0;
    bus.a_int = '0; bus.a_frac = '0; bus.a_sign = 1'b0; bus.a_zero = 1'b0;
    bus.b_int = '0; bus.b_frac = '0; bus.b_sign = 1'b0; bus.b_zero = 1'b0;
    bus.data_in_valid = 1'b0;
    bus.data_out_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus.data_out_valid), 32'd0);
    check("reset_outputs", 32'(observed()), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_enable", 32'(bus.data_in_enable), 32'd1);

    // Directed cases from the plan
    send(8'd0,   8'h80, 1'b0, 1'b0, 8'd0,   8'h40, 1'b0, 1'b0);
    check("first_latency_valid", 32'(bus.data_out_valid), 32'd1);
    check("first_value", 32'(observed()), 32'({8'd0, 8'hC0, 1'b0, 1'b0, 1'b0}));
    send(8'd1,   8'h80, 1'b1, 1'b0, 8'd0,   8'h80, 1'b0, 1'b0);
    send(8'hFF,  8'hC0, 1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0);
    send(8'd127, 8'hFF, 1'b0, 1'b0, 8'd1,   8'h00, 1'b0, 1'b0);
    send(8'h80,  8'h00, 1'b0, 1'b0, 8'hFF,  8'h00, 1'b0, 1'b0);
    send(8'd0,   8'h00, 1'b1, 1'b1, 8'd5,   8'h33, 1'b1, 1'b0);
    drain();

    // Backpressure: fill, third push must wait for a pop
    bus.data_out_enable = 1'b0;
    send(8'd3, 8'h10, 1'b0, 1'b0, 8'd4, 8'h20, 1'b1, 1'b0);
    send(8'd5, 8'h30, 1'b1, 1'b0, 8'd6, 8'h40, 1'b1, 1'b0);
    check("full_in_enable", 32'(bus.data_in_enable), 32'd0);
    fork
      send(8'd7, 8'h50, 1'b0, 1'b0, 8'hFE, 8'h60, 1'b1, 1'b0);
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("stall_in_enable", 32'(bus.data_in_enable), 32'd0);
    check("stall_depth", 32'(exp_q.size()), 32'(DP));
    bus.data_out_enable = 1'b1;
    wait fork;
    drain();

    // Asynchronous reset with FIFO full
    bus.data_out_enable = 1'b0;
    send(8'd9,  8'h01, 1'b0, 1'b0, 8'd2, 8'h02, 1'b0, 1'b0);
    send(8'd10, 8'h03, 1'b1, 1'b0, 8'd2, 8'h04, 1'b0, 1'b0);
    check("prereset_full", 32'(bus.data_in_enable), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_valid", 32'(bus.data_out_valid), 32'd0);
    check("async_reset_outputs", 32'(observed()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.data_out_enable = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_enable", 32'(bus.data_in_enable), 32'd1);
    check("post_reset_no_stale", 32'(bus.data_out_valid), 32'd0);

    // Random operands with random consumer readiness
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(IB'($urandom), XB'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
           IB'($urandom), XB'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      #0;
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    drain();
    check("final_valid", 32'(bus.data_out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/lns_log_multiply_stage.md
Name: lns_log_multiply_stage

Overview:
Log-domain multiply stage of the LNS MAC, sitting directly upstream of the DeLugish exponentiation unit. It accepts two LNS operands, adds their log magnitudes with saturation, and XORs their signs. It splits the result into a signed integer part and an unsigned fraction; the fraction (X_BITS) drives the exponentiator's data_in. A DEPTH-entry output FIFO absorbs backpressure from the exponentiator's data_in_enable.

Parameters:
X_BITS, 8, fraction bits of log value; must equal the exponentiator's X_BITS
INT_BITS, 8, signed two's-complement integer bits of log value
DEPTH, 2, output FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
a_int  in  INT_BITS  operand A log integer part (signed)
a_frac  in  X_BITS  operand A log fraction (unsigned)
a_sign  in  1  operand A sign (1 = negative)
a_zero  in  1  operand A is exact zero
b_int, b_frac, b_sign, b_zero  in  INT_BITS/X_BITS/1/1  operand B, same format
data_in_valid  in  1  operand pair valid
data_in_enable  out  1  stage can accept (ready)
data_out_frac  out  X_BITS  product log fraction; to exponentiator data_in
data_out_int  out  INT_BITS  product log integer part (floor), signed
data_out_sign  out  1  product sign
data_out_zero  out  1  product is zero
data_out_sat  out  1  log sum saturated
data_out_valid  out  1  FIFO head valid
data_out_enable  in  1  consumer ready (exponentiator data_in_enable)

Behaviour:
- Reset (async, rstn=0): FIFO empty, count=0, all data_out_* = 0, data_out_valid=0, data_in_enable=1 once rstn deasserts. Reset mid-operation discards all FIFO contents.
- Log value L = {int, frac} read as signed fixed point, W = INT_BITS+X_BITS bits.
- Sum S = La + Lb computed at W+1 bits and clamped to [-2^(W-1), 2^(W-1)-1]. On clamp, sat=1; otherwise sat=0.
- data_out_int = S[W-1:X_BITS] and data_out_frac = S[X_BITS-1:0]. The split is floor-based, so the fraction is always non-negative.
- sign = a_sign ^ b_sign.
- Zero: if a_zero | b_zero, then zero=1 and int, frac, sign and sat are all forced to 0.
- Handshake: a push occurs when data_in_valid & data_in_enable. A pop occurs when data_out_valid & data_out_enable.
- data_in_enable = (count != DEPTH). It depends only on registered state, with no combinational path from data_out_enable.
- Results are computed combinationally and written into the FIFO on the push edge.
- Latency: 1 cycle. The result appears at the head the cycle after the push when the FIFO was empty.
- data_out_valid = (count != 0). data_out_* always shows the head entry and is held stable while valid & !enable.
- Push and pop in the same cycle: count unchanged, order preserved. At count=DEPTH no push occurs (enable low). At count=0 pop is ignored.
- Pointers wrap modulo DEPTH. Data stays in strict FIFO order.
- Inputs are ignored when data_in_valid=0 or data_in_enable=0.

Test Plan:
- Reset, then push A={0,0x80,+}, B={0,0x40,+} (0.5+0.25) -> next cycle valid=1, frac=0xC0, int=0, sign=0, sat=0.
- Push A={1,0x80} (1.5) and B={0,0x80} (0.5), with a_sign=1 and b_sign=0 -> int=2, frac=0x00, sign=1.
- Push A={-1(0xFF),0xC0} (-0.25) and B={0,0x00} -> int=0xFF, frac=0xC0. Push A={127,0xFF} and B={1,0x00} -> int=127, frac=0xFF, sat=1. Push A={-128,0x00} and B={-1,0x00} -> int=-128, frac=0x00, sat=1.
- Push with a_zero=1 and nonzero B -> zero=1, int=0, frac=0, sign=0, sat=0.
- Hold data_out_enable=0 and push 3 pairs back-to-back -> data_in_enable drops after 2 pushes and the 3rd is not accepted until a pop. Head stays stable while stalled. Raising enable drains results in push order.
- Pulse rstn=0 mid-stream with FIFO full -> data_out_valid=0 and outputs 0 immediately (async). After release, data_in_enable=1 and no stale data appears.
